// File: rtl/axi_lite_template.sv
// AXI4-Lite slave with a 32-entry register file (index = addr[6:2], aliasing modulo 0x80).
// All outputs are flops; AW, W and AR are accepted independently and every access returns OKAY.
module axi_lite_template #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [C_ADDR_WIDTH-1:0]   awaddr,
  input  logic [2:0]                awprot,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [C_DATA_WIDTH-1:0]   wdata,
  input  logic [C_DATA_WIDTH/8-1:0] wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [C_ADDR_WIDTH-1:0]   araddr,
  input  logic [2:0]                arprot,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [C_DATA_WIDTH-1:0]   rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid holds its payload until that edge, and ready never depends combinationally on valid.

  localparam int STRB_W = C_DATA_WIDTH / 8;
  localparam int N_REGS = 32;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  logic [C_DATA_WIDTH-1:0] regs [N_REGS];

  logic                    aw_held;
  logic                    w_held;
  logic [4:0]              aw_idx;
  logic [C_DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]       w_strb;

  logic aw_hs, w_hs, ar_hs;
  logic commit, b_done, r_done;
  logic aw_held_nxt, w_held_nxt, bvalid_nxt, rvalid_nxt;

  // Protection bits and the address bits outside [6:2] have no effect.
  logic unused_inputs;
  assign unused_inputs = ^{awprot, arprot, awaddr, araddr};

  always_comb begin
    aw_hs       = awvalid & awready;
    w_hs        = wvalid & wready;
    ar_hs       = arvalid & arready;
    commit      = aw_held & w_held & ~bvalid;
    b_done      = bvalid & bready;
    r_done      = rvalid & rready;
    aw_held_nxt = aw_held;
    w_held_nxt  = w_held;
    bvalid_nxt  = bvalid;
    rvalid_nxt  = rvalid;
    if (aw_hs)  aw_held_nxt = 1'b1;
    if (w_hs)   w_held_nxt  = 1'b1;
    if (commit) bvalid_nxt  = 1'b1;
    // The response handshake retires the whole write, freeing both capture slots.
    if (b_done) begin
      bvalid_nxt  = 1'b0;
      aw_held_nxt = 1'b0;
      w_held_nxt  = 1'b0;
    end
    if (ar_hs)       rvalid_nxt = 1'b1;
    else if (r_done) rvalid_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rresp   <= RESP_OKAY;
      rdata   <= '0;
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
    end else begin
      aw_held <= aw_held_nxt;
      w_held  <= w_held_nxt;
      bvalid  <= bvalid_nxt;
      rvalid  <= rvalid_nxt;
      awready <= ~aw_held_nxt & ~bvalid_nxt;
      wready  <= ~w_held_nxt & ~bvalid_nxt;
      arready <= ~rvalid_nxt;
      bresp   <= RESP_OKAY;
      rresp   <= RESP_OKAY;
      if (aw_hs) aw_idx <= awaddr[6:2];
      if (w_hs) begin
        w_data <= wdata;
        w_strb <= wstrb;
      end
      if (commit) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (w_strb[b]) regs[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
      // Samples the pre-update array, so a read colliding with a commit sees the old value.
      if (ar_hs) rdata <= regs[araddr[6:2]];
    end
  end

endmodule

// File: tb/tb_axi_lite_template.sv
// Directed self-checking bench for axi_lite_template: register sweep, byte strobes,
// split AW/W, back-pressure, read/write collision, aliasing and reset behaviour.
module tb_axi_lite_template;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int n_checks = 0;
  int n_pass   = 0;
  int bv_rise  = 0;
  logic bvalid_prev = 1'b0;
  logic [31:0] exp_q[$];

  axi_lite_template #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  // Counts rising edges of bvalid, sampled away from the active edge
  always @(negedge clk) begin
    if (bvalid && !bvalid_prev) bv_rise++;
    bvalid_prev = bvalid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_b(input string tag);
    bready = 1'b1;
    for (int c = 0; c < 16 && !bvalid; c++) step();
    check({tag, "_bvalid"}, bvalid, 1);
    check({tag, "_bresp"}, bresp, 0);
    step();
    bready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input string tag);
    logic hs_aw, hs_w;
    awaddr  = addr;
    wdata   = data;
    wstrb   = strb;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    for (int c = 0; c < 16 && (awvalid || wvalid); c++) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      step();
      if (hs_aw) awvalid = 1'b0;
      if (hs_w)  wvalid  = 1'b0;
    end
    check({tag, "_aw_w_hs"}, {awvalid, wvalid}, 0);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    wait_b(tag);
  endtask

  // Pops the expected read value from the scoreboard queue
  task automatic axi_read(input logic [31:0] addr, input string tag);
    logic hs;
    logic [31:0] exp;
    araddr  = addr;
    arvalid = 1'b1;
    for (int c = 0; c < 16 && arvalid; c++) begin
      hs = arready;
      step();
      if (hs) arvalid = 1'b0;
    end
    check({tag, "_ar_hs"}, arvalid, 0);
    arvalid = 1'b0;
    rready  = 1'b1;
    for (int c = 0; c < 16 && !rvalid; c++) step();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_rvalid"}, rvalid, 1);
    check({tag, "_rdata"}, rdata, exp);
    check({tag, "_rresp"}, rresp, 0);
    step();
    rready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, awready, 0);
    check({tag, "_wready"}, wready, 0);
    check({tag, "_arready"}, arready, 0);
    check({tag, "_bvalid"}, bvalid, 0);
    check({tag, "_rvalid"}, rvalid, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_bresp"}, bresp, 0);
    check({tag, "_rresp"}, rresp, 0);
  endtask

  task automatic check_readies(input string tag);
    check({tag, "_awready"}, awready, 1);
    check({tag, "_wready"}, wready, 1);
    check({tag, "_arready"}, arready, 1);
  endtask

  initial begin
    int rises0;
    logic hs;
    rst = 1'b1; awaddr = '0; awprot = 3'b010; awvalid = 1'b0; wdata = '0; wstrb = '0;
    wvalid = 1'b0; bready = 1'b0; araddr = '0; arprot = 3'b101; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;
    step();
    check_readies("por_release");

    // Sweep all 32 registers
    for (int i = 0; i < 32; i++) axi_write(32'(4 * i), 32'(i), 4'hF, $sformatf("sweep_w%0d", i));
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(32'(i));
      axi_read(32'(4 * i), $sformatf("sweep_r%0d", i));
    end

    // Byte strobes: clear bytes 0 and 2 only
    axi_write(32'h08, 32'hFFFF_FFFF, 4'hF, "strb_full");
    axi_write(32'h08, 32'h0000_0000, 4'b0101, "strb_part");
    exp_q.push_back(32'hFF00_FF00);
    axi_read(32'h08, "strb_rd");

    // AW leads W by 3 cycles
    rises0  = bv_rise;
    awaddr  = 32'h10;
    wdata   = 32'hA5A5_A5A5;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    hs = awready;
    step();
    check("lead_aw_hs", hs, 1);
    awvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("lead_awready_c%0d", c), awready, 0);
      check($sformatf("lead_bvalid_c%0d", c), bvalid, 0);
      step();
    end
    wvalid = 1'b1;
    hs = wready;
    step();
    check("lead_w_hs", hs, 1);
    wvalid = 1'b0;
    check("lead_bvalid_before_commit", bvalid, 0);
    wait_b("lead");
    repeat (2) step();
    check("lead_bvalid_rises", 32'(bv_rise - rises0), 1);
    exp_q.push_back(32'hA5A5_A5A5);
    axi_read(32'h10, "lead_rd");

    // Back-pressure on both response channels for 5 cycles
    awaddr = 32'h14; wdata = 32'h0BAD_F00D; wstrb = 4'hF; araddr = 32'h08;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall_bvalid_c%0d", c), bvalid, 1);
      check($sformatf("stall_rvalid_c%0d", c), rvalid, 1);
      check($sformatf("stall_rdata_c%0d", c), rdata, 32'hFF00_FF00);
      check($sformatf("stall_readies_c%0d", c), {awready, wready, arready}, 0);
      step();
    end
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    check("stall_release_valids", {bvalid, rvalid}, 0);
    check_readies("stall_release");
    exp_q.push_back(32'h0BAD_F00D);
    axi_read(32'h14, "stall_wr_rd");

    // Read captured on the same edge as a write to the same register
    axi_write(32'h1C, 32'h1111_1111, 4'hF, "coll_pre");
    awaddr = 32'h1C; wdata = 32'h2222_2222; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h1C; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    check("coll_bvalid", bvalid, 1);
    check("coll_rvalid", rvalid, 1);
    check("coll_rdata_old", rdata, 32'h1111_1111);
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    exp_q.push_back(32'h2222_2222);
    axi_read(32'h1C, "coll_rd_new");

    // Address aliasing modulo 0x80
    axi_write(32'h84, 32'h1234_5678, 4'hF, "alias_w");
    exp_q.push_back(32'h1234_5678);
    axi_read(32'h04, "alias_rd");

    // Reset after a completed write clears the register file
    axi_write(32'h0C, 32'hCAFE_BABE, 4'hF, "rst_pre_w");
    exp_q.push_back(32'hCAFE_BABE);
    axi_read(32'h0C, "rst_pre_rd");
    rst = 1'b1;
    step();
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    step();
    check_readies("rst_release");
    exp_q.push_back(32'h0);
    axi_read(32'h0C, "rst_rd_0c");
    exp_q.push_back(32'h0);
    axi_read(32'h08, "rst_rd_08");

    // Reset between capture and commit aborts the write
    awaddr = 32'h18; wdata = 32'h55AA_55AA; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    rises0 = bv_rise;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check_readies("abort_release");
    repeat (2) begin
      check("abort_bvalid", bvalid, 0);
      step();
    end
    check("abort_bvalid_rises", 32'(bv_rise - rises0), 0);
    exp_q.push_back(32'h0);
    axi_read(32'h18, "abort_rd");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_template.md
AXI_LITE_TEMPLATE -- requirements
Module: axi_lite_template

Interface
REQ-001 The module SHALL have a parameter C_DATA_WIDTH, default 32, giving the AXI data width in bits; only 32 needs to be supported.
REQ-002 The module SHALL have a parameter C_ADDR_WIDTH, default 32, giving the AXI address width in bits; it SHALL be at least 7.
REQ-003 The module SHALL have a port clk, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-004 The module SHALL have a port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 The write-address channel SHALL be: awaddr in C_ADDR_WIDTH; awprot in 3 (ignored); awvalid in 1; awready out 1.
REQ-006 The write-data channel SHALL be: wdata in C_DATA_WIDTH; wstrb in C_DATA_WIDTH/8 (byte enables); wvalid in 1; wready out 1.
REQ-007 The write-response channel SHALL be: bresp out 2; bvalid out 1; bready in 1.
REQ-008 The read-address channel SHALL be: araddr in C_ADDR_WIDTH; arprot in 3 (ignored); arvalid in 1; arready out 1.
REQ-009 The read-data channel SHALL be: rdata out C_DATA_WIDTH; rresp out 2; rvalid out 1; rready in 1.

Function
REQ-010 The block SHALL implement an AXI4-Lite slave register file of 32 registers, each C_DATA_WIDTH bits, with register index = addr[6:2].
- addr[1:0] are ignored.
- addr bits above bit 6 are ignored, so addresses alias modulo 0x80.
REQ-011 Every access SHALL complete with response OKAY: bresp = 2'b00, rresp = 2'b00. No SLVERR or DECERR is ever generated.
REQ-012 Write address capture SHALL work as follows:
- awready = 1 while no write address is held and bvalid = 0.
- On awvalid & awready, awaddr is latched and awready drops the next cycle.
REQ-013 Write data capture SHALL work as follows:
- wready = 1 while no write data is held and bvalid = 0.
- On wvalid & wready, wdata and wstrb are latched and wready drops the next cycle.
REQ-014 The AW and W channels SHALL be accepted independently in any order, including the same cycle.
REQ-015 When both address and data are held, the target register SHALL be updated on that clock edge and bvalid SHALL assert on the same edge.
- Only bytes with wstrb[n] = 1 are updated.
- Latency when AW and W handshake in the same cycle: update and bvalid one cycle later.
REQ-016 bvalid SHALL hold until bready = 1, then deassert on the next edge.
- The held AW and W are cleared at the same edge.
- awready and wready reassert after that edge.
REQ-017 arready SHALL be 1 while rvalid = 0.
- On arvalid & arready, rdata is loaded with the addressed register and rvalid asserts on the next edge.
- Read latency is 1 cycle.
REQ-018 rdata and rvalid SHALL hold stable until rready = 1; rvalid then clears on the next edge and arready reasserts.
REQ-019 When a read and a write to the same register are captured on the same edge, the read SHALL return the pre-write value.
REQ-020 The read and write paths SHALL be fully independent; neither blocks the other.
REQ-021 Outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-022 While rst = 1 at a rising clk edge, all of the following SHALL be cleared to 0:
- awready, wready, bvalid, arready, rvalid, bresp, rresp and rdata;
- all 32 registers;
- the held AW and W state.
REQ-023 Reset asserted mid-transaction SHALL abort that transaction: no register write and no response occur.
REQ-024 awready, wready and arready SHALL return to 1 on the first edge after rst deasserts.

Verification
REQ-025 Loop i = 0..31: write data i to address 4*i with wstrb = 4'hF, then read 4*i -> rdata == i, rresp == 0 and bresp == 0 for every access.
REQ-026 Write 0xFFFFFFFF to address 0x08, then write 0x00000000 with wstrb = 4'b0101 -> reading 0x08 returns 0xFF00FF00.
REQ-027 Present AW 3 cycles before W, with data 0xA5A5A5A5 to address 0x10 -> exactly one write, bvalid asserts once, and reading 0x10 returns 0xA5A5A5A5.
REQ-028 Hold bready = 0 and rready = 0 for 5 cycles -> bvalid, rvalid and rdata stay stable, and awready, wready and arready stay 0 until the handshake completes.
REQ-029 Write 0x12345678 to address 0x84, then read address 0x04 -> returns 0x12345678 (alias).
REQ-030 Assert rst after a write to address 0x0C completes -> a subsequent read of 0x0C returns 0, and all handshake outputs follow REQ-022/REQ-024.
